// File: rtl/echo_pkg.sv
// Shared types and defaults for the echo responder slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package echo_pkg;

   localparam int ECHO_WIDTH = 32;
   localparam int ECHO_DEPTH = 4;

   // Responder sequencing: pop head, optionally wait, then hold the indication.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } echo_state_t;

endpackage

// File: rtl/echo_sync_fifo.sv
// Synchronous FIFO with show-ahead read data and an occupancy count.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full/empty.
module echo_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign pop_dat = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat;
   end

endmodule

// File: rtl/echo_responder.sv
// Echo responder: buffers fifo_enq requests and replays each payload on ind_heard.
// Latency: request accepted in cycle t reaches ind_heard__ENA in cycle t+2+DELAY.
// Backpressure: SEND holds while ind_heard__RDY=0; fifo_enq__RDY drops when the FIFO is full.
module echo_responder
   import echo_pkg::*;
#(
   parameter int WIDTH = ECHO_WIDTH,
   parameter int DEPTH = ECHO_DEPTH,
   parameter int DELAY = 0
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             fifo_enq__ENA,
   input  logic [WIDTH-1:0] fifo_enq_v,
   output logic             fifo_enq__RDY,
   input  logic             ind_heard__RDY,
   output logic             ind_heard__ENA,
   output logic [WIDTH-1:0] ind_heard_v,
   output logic [31:0]      echo_count,
   output logic             busy,
   output logic             proto_err
);

   localparam logic [7:0] DELAY_CNT = 8'(DELAY);

   echo_state_t           state_q, state_d;
   logic [7:0]            dcnt_q, dcnt_d;
   logic [WIDTH-1:0]      out_q, out_d;
   logic [31:0]           echo_count_q, echo_count_d;
   logic                  proto_err_q, proto_err_d;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic [WIDTH-1:0]      fifo_dat;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;

   // Ready is held low during reset so nothing is accepted into a FIFO being cleared.
   assign fifo_enq__RDY  = ~nRST & ~fifo_full;
   assign fifo_push      = fifo_enq__ENA & fifo_enq__RDY;

   assign ind_heard__ENA = (state_q == SEND);
   assign ind_heard_v    = out_q;
   assign echo_count     = echo_count_q;
   assign proto_err      = proto_err_q;
   assign busy           = (fifo_count != '0) || (state_q != IDLE);

   echo_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst      (nRST),
      .push     (fifo_push),
      .push_dat (fifo_enq_v),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Next-state, pop decision and datapath updates for the echo sequencer.
   always_comb begin
      state_d      = state_q;
      dcnt_d       = dcnt_q;
      out_d        = out_q;
      echo_count_d = echo_count_q;
      fifo_pop     = 1'b0;
      // A request offered while not ready is lost; remember it until reset.
      proto_err_d  = proto_err_q | (fifo_enq__ENA & ~fifo_enq__RDY);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               out_d    = fifo_dat;
               dcnt_d   = DELAY_CNT;
               state_d  = (DELAY_CNT == 8'd0) ? SEND : WAIT;
            end
         end
         WAIT: begin
            dcnt_d = dcnt_q - 8'd1;
            if (dcnt_q == 8'd1) state_d = SEND;
         end
         SEND: begin
            if (ind_heard__RDY) begin
               echo_count_d = echo_count_q + 32'd1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; reset discards any in-flight echo.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_q      <= IDLE;
         dcnt_q       <= '0;
         out_q        <= '0;
         echo_count_q <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dcnt_q       <= dcnt_d;
         out_q        <= out_d;
         echo_count_q <= echo_count_d;
         proto_err_q  <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_echo_responder.sv
// Bench for echo_responder: cycle table on a DELAY=0 instance, hand sequences for
// delay, pop/push overlap, reset and counter wrap, and per-instance echo scoreboards.
module tb_echo_responder;

   logic        CLK = 1'b0;
   logic        nRST = 1'b1;

   logic        enq_ena0 = 1'b0, enq_rdy0, h_rdy0 = 1'b0, h_ena0, busy0, perr0;
   logic [31:0] enq_v0 = '0, h_v0, cnt0;
   logic        enq_ena3 = 1'b0, enq_rdy3, h_rdy3 = 1'b0, h_ena3, busy3, perr3;
   logic [31:0] enq_v3 = '0, h_v3, cnt3;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] sb0[$];
   logic [31:0] sb3[$];

   always #5 CLK = ~CLK;

   echo_responder #(.WIDTH(32), .DEPTH(4), .DELAY(0)) u_dut0 (
      .CLK(CLK), .nRST(nRST),
      .fifo_enq__ENA(enq_ena0), .fifo_enq_v(enq_v0), .fifo_enq__RDY(enq_rdy0),
      .ind_heard__RDY(h_rdy0), .ind_heard__ENA(h_ena0), .ind_heard_v(h_v0),
      .echo_count(cnt0), .busy(busy0), .proto_err(perr0)
   );

   echo_responder #(.WIDTH(32), .DEPTH(4), .DELAY(3)) u_dut3 (
      .CLK(CLK), .nRST(nRST),
      .fifo_enq__ENA(enq_ena3), .fifo_enq_v(enq_v3), .fifo_enq__RDY(enq_rdy3),
      .ind_heard__RDY(h_rdy3), .ind_heard__ENA(h_ena3), .ind_heard_v(h_v3),
      .echo_count(cnt3), .busy(busy3), .proto_err(perr3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboards: push on accepted request, pop and compare on indication handshake.
   always @(negedge CLK) begin
      if (nRST) begin
         sb0.delete();
      end else begin
         if (h_ena0 && h_rdy0) begin
            if (sb0.size() == 0) chk("sb0_unexpected_echo", 32'd1, 32'd0);
            else chk("sb0_echo_value", h_v0, sb0.pop_front());
         end
         if (enq_ena0 && enq_rdy0) sb0.push_back(enq_v0);
      end
   end

   always @(negedge CLK) begin
      if (nRST) begin
         sb3.delete();
      end else begin
         if (h_ena3 && h_rdy3) begin
            if (sb3.size() == 0) chk("sb3_unexpected_echo", 32'd1, 32'd0);
            else chk("sb3_echo_value", h_v3, sb3.pop_front());
         end
         if (enq_ena3 && enq_rdy3) sb3.push_back(enq_v3);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        ena;
      logic [31:0] v;
      logic        hrdy;
      logic        x_rdy;
      logic        x_ena;
      logic [31:0] x_v;
      logic [31:0] x_cnt;
      logic        x_busy;
      logic        x_perr;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(int ena, int v, int hrdy, int x_rdy, int x_ena,
                               int x_v, int x_cnt, int x_busy, int x_perr);
      vec_t r;
      r.ena    = (ena != 0);
      r.v      = 32'(v);
      r.hrdy   = (hrdy != 0);
      r.x_rdy  = (x_rdy != 0);
      r.x_ena  = (x_ena != 0);
      r.x_v    = 32'(x_v);
      r.x_cnt  = 32'(x_cnt);
      r.x_busy = (x_busy != 0);
      r.x_perr = (x_perr != 0);
      tbl.push_back(r);
   endfunction

   initial begin
      int lat;
      int guard;

      //   ena  v  hrdy | rdy ena  v  cnt busy perr
      add(0,  0, 1,     1, 0,  0, 0, 0, 0);   // c0 idle after reset
      add(1, 22, 1,     1, 0,  0, 0, 0, 0);   // c1 request 22
      add(0,  0, 1,     1, 0,  0, 0, 1, 0);   // c2 queued, IDLE pops
      add(0,  0, 1,     1, 1, 22, 0, 1, 0);   // c3 indication, handshake
      add(0,  0, 1,     1, 0, 22, 1, 0, 0);   // c4 count advanced
      add(1,  1, 0,     1, 0, 22, 1, 0, 0);   // c5 burst with consumer stalled
      add(1,  2, 0,     1, 0, 22, 1, 1, 0);
      add(1,  3, 0,     1, 1,  1, 1, 1, 0);
      add(1,  4, 0,     1, 1,  1, 1, 1, 0);
      add(1,  5, 0,     1, 1,  1, 1, 1, 0);
      add(1,  6, 0,     0, 1,  1, 1, 1, 0);   // c10 FIFO full, 6 dropped
      add(0,  0, 0,     0, 1,  1, 1, 1, 1);   // c11 sticky error
      add(0,  0, 1,     0, 1,  1, 1, 1, 1);   // c12 drain begins
      add(0,  0, 1,     0, 0,  1, 2, 1, 1);
      add(0,  0, 1,     1, 1,  2, 2, 1, 1);
      add(0,  0, 1,     1, 0,  2, 3, 1, 1);
      add(0,  0, 1,     1, 1,  3, 3, 1, 1);
      add(0,  0, 1,     1, 0,  3, 4, 1, 1);
      add(0,  0, 1,     1, 1,  4, 4, 1, 1);
      add(0,  0, 1,     1, 0,  4, 5, 1, 1);
      add(0,  0, 1,     1, 1,  5, 5, 1, 1);
      add(0,  0, 1,     1, 0,  5, 6, 0, 1);   // c21 drained

      // Reset: ready forced low while reset is asserted.
      repeat (3) tick();
      @(negedge CLK);
      chk("rst_enq_rdy_low", {31'd0, enq_rdy0}, 32'd0);
      tick();
      nRST = 1'b0;

      // Cycle table on the DELAY=0 instance.
      foreach (tbl[i]) begin
         enq_ena0 = tbl[i].ena;
         enq_v0   = tbl[i].v;
         h_rdy0   = tbl[i].hrdy;
         @(negedge CLK);
         chk($sformatf("tbl%0d_enq_rdy", i), {31'd0, enq_rdy0}, {31'd0, tbl[i].x_rdy});
         chk($sformatf("tbl%0d_h_ena", i), {31'd0, h_ena0}, {31'd0, tbl[i].x_ena});
         chk($sformatf("tbl%0d_h_v", i), h_v0, tbl[i].x_v);
         chk($sformatf("tbl%0d_count", i), cnt0, tbl[i].x_cnt);
         chk($sformatf("tbl%0d_busy", i), {31'd0, busy0}, {31'd0, tbl[i].x_busy});
         chk($sformatf("tbl%0d_perr", i), {31'd0, perr0}, {31'd0, tbl[i].x_perr});
         tick();
      end
      enq_ena0 = 1'b0;

      // DELAY=3: first indication five cycles after acceptance, held until ready.
      h_rdy3   = 1'b0;
      enq_ena3 = 1'b1;
      enq_v3   = 32'hA5A5_A5A5;
      @(negedge CLK);
      chk("d3_enq_rdy", {31'd0, enq_rdy3}, 32'd1);
      tick();
      enq_ena3 = 1'b0;
      lat = 1;
      forever begin
         @(negedge CLK);
         if (h_ena3 || lat > 20) break;
         tick();
         lat++;
      end
      chk("d3_latency", lat, 32'd5);
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge CLK);
         chk("d3_hold_ena", {31'd0, h_ena3}, 32'd1);
         chk("d3_hold_v", h_v3, 32'hA5A5_A5A5);
      end
      tick();
      h_rdy3 = 1'b1;
      @(negedge CLK);
      tick();
      @(negedge CLK);
      chk("d3_count", cnt3, 32'd1);
      chk("d3_ena_drop", {31'd0, h_ena3}, 32'd0);

      // Push in the same cycle IDLE pops: occupancy unchanged, order kept.
      tick();
      h_rdy0 = 1'b0;
      for (int k = 10; k <= 13; k++) begin
         enq_ena0 = 1'b1;
         enq_v0   = 32'(k);
         @(negedge CLK);
         tick();
      end
      enq_ena0 = 1'b0;
      @(negedge CLK);
      chk("ovl_occ_before", 32'(u_dut0.fifo_count), 32'd3);
      chk("ovl_send_v", h_v0, 32'd10);
      tick();
      h_rdy0 = 1'b1;
      @(negedge CLK);
      tick();
      enq_ena0 = 1'b1;
      enq_v0   = 32'd14;
      @(negedge CLK);
      chk("ovl_idle_ena", {31'd0, h_ena0}, 32'd0);
      chk("ovl_enq_rdy", {31'd0, enq_rdy0}, 32'd1);
      tick();
      enq_ena0 = 1'b0;
      @(negedge CLK);
      chk("ovl_occ_after", 32'(u_dut0.fifo_count), 32'd3);
      guard = 0;
      while (busy0 && guard < 40) begin
         tick();
         @(negedge CLK);
         guard++;
      end
      chk("ovl_drain_timeout", 32'(guard < 40), 32'd1);
      chk("ovl_count", cnt0, 32'd11);

      // Reset during SEND with two entries queued.
      tick();
      h_rdy0 = 1'b0;
      for (int k = 20; k <= 22; k++) begin
         enq_ena0 = 1'b1;
         enq_v0   = 32'(k);
         @(negedge CLK);
         tick();
      end
      enq_ena0 = 1'b0;
      @(negedge CLK);
      chk("rst2_pre_ena", {31'd0, h_ena0}, 32'd1);
      chk("rst2_pre_occ", 32'(u_dut0.fifo_count), 32'd2);
      tick();
      nRST = 1'b1;
      @(negedge CLK);
      chk("rst2_enq_rdy_low", {31'd0, enq_rdy0}, 32'd0);
      tick();
      nRST = 1'b0;
      @(negedge CLK);
      chk("rst2_ena", {31'd0, h_ena0}, 32'd0);
      chk("rst2_busy", {31'd0, busy0}, 32'd0);
      chk("rst2_count", cnt0, 32'd0);
      chk("rst2_enq_rdy", {31'd0, enq_rdy0}, 32'd1);
      chk("rst2_perr", {31'd0, perr0}, 32'd0);
      tick();
      h_rdy0   = 1'b1;
      enq_ena0 = 1'b1;
      enq_v0   = 32'd99;
      @(negedge CLK);
      tick();
      enq_ena0 = 1'b0;
      guard = 0;
      @(negedge CLK);
      while (busy0 && guard < 40) begin
         tick();
         @(negedge CLK);
         guard++;
      end
      chk("rst2_post_count", cnt0, 32'd1);

      // Counter wrap: preload all-ones while an echo is held, then complete it.
      tick();
      h_rdy0   = 1'b0;
      enq_ena0 = 1'b1;
      enq_v0   = 32'd77;
      @(negedge CLK);
      tick();
      enq_ena0 = 1'b0;
      guard = 0;
      @(negedge CLK);
      while (!h_ena0 && guard < 20) begin
         tick();
         @(negedge CLK);
         guard++;
      end
      chk("wrap_send_reached", {31'd0, h_ena0}, 32'd1);
      force u_dut0.echo_count_q = 32'hFFFF_FFFF;
      tick();
      @(negedge CLK);
      release u_dut0.echo_count_q;
      tick();
      h_rdy0 = 1'b1;
      @(negedge CLK);
      tick();
      @(negedge CLK);
      chk("wrap_count", cnt0, 32'd0);

      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb3_drained", 32'(sb3.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
